// File: rtl/pipe_ctrl_32.sv
// Control end of a DEPTH-stage pipe register chain: per-stage enables, clears, valid tracking,
// global stall timer and squashed-item counter. Optional macro PIPE_CTRL_BUBBLE_COLLAPSE_EN.
`timescale 1ns/1ps
module pipe_ctrl_32 #(
    parameter int DEPTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DEPTH-1:0] stall_req,
    input  logic [DEPTH-1:0] squash_req,
    input  logic             stall_load,
    input  logic [CNTW-1:0]  stall_cycles,
    output logic [DEPTH-1:0] en,
    output logic [DEPTH-1:0] squash,
    output logic [DEPTH-1:0] valid,
    output logic             busy,
    output logic             global_stall,
    output logic [CNTW-1:0]  squash_cnt
);

    localparam int KW = $clog2(DEPTH + 1);
    localparam int SW = CNTW + KW;

    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [DEPTH-1:0] stall_mask, squash_mask, bubble, frozen, en_int, squash_int, kill;
    logic [CNTW-1:0]  cnt_reg, cnt_next, cnt_dec;
    logic [CNTW-1:0]  sq_cnt_reg, sq_cnt_next;
    logic [KW-1:0]    kill_count;
    logic [SW-1:0]    sq_sum;

    assign global_stall = (cnt_reg != '0);

    // stall_mask[j] / squash_mask[j]: some request at index >= j (i.e. j <= kmax / smax).
    always_comb begin
        stall_mask  = '0;
        squash_mask = '0;
        stall_mask[DEPTH-1]  = stall_req[DEPTH-1];
        squash_mask[DEPTH-1] = squash_req[DEPTH-1];
        for (int j = DEPTH - 2; j >= 0; j--) begin
            stall_mask[j]  = stall_req[j] | stall_mask[j+1];
            squash_mask[j] = squash_req[j] | squash_mask[j+1];
        end
    end

`ifdef PIPE_CTRL_BUBBLE_COLLAPSE_EN
    logic [DEPTH-1:0] hole;

    // hole[j]: an empty register exists in j..kmax, so register j has room to advance.
    always_comb begin
        hole = '0;
        hole[DEPTH-1] = ~valid_reg[DEPTH-1];
        for (int j = DEPTH - 2; j >= 0; j--) begin
            hole[j] = ~valid_reg[j] | (stall_mask[j+1] & hole[j+1]);
        end
    end
    assign frozen = stall_mask & ~hole;
`else
    assign frozen = stall_mask;
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic src_valid;
            if (gi == 0) begin : g_first
                assign bubble[gi] = 1'b0;
                assign src_valid  = in_valid;
            end else begin : g_rest
                // Register just above the highest stalled one would otherwise copy the held item.
                assign bubble[gi] = stall_req[gi-1] & ~stall_mask[gi] & ~global_stall;
                assign src_valid  = valid_reg[gi-1];
            end
            assign en_int[gi]     = ~global_stall & ~frozen[gi];
            assign squash_int[gi] = squash_mask[gi] | bubble[gi];
            assign valid_next[gi] = squash_int[gi] ? 1'b0 :
                                    en_int[gi]     ? src_valid : valid_reg[gi];
        end
    endgenerate

    assign en       = reset ? '0 : en_int;
    assign squash   = reset ? '1 : squash_int;
    assign in_ready = en[0] & ~squash[0];
    assign valid    = valid_reg;
    assign busy     = |valid_reg;

    // A pure bubble clear loses nothing: that register's item advances in the same cycle.
    assign kill = valid_reg & squash_int & ~(bubble & ~squash_mask);

    always_comb begin
        kill_count = '0;
        for (int j = 0; j < DEPTH; j++) begin
            kill_count = kill_count + KW'(kill[j]);
        end
        sq_sum = SW'(sq_cnt_reg) + SW'(kill_count);
        if (sq_sum > SW'({CNTW{1'b1}})) begin
            sq_cnt_next = '1;
        end else begin
            sq_cnt_next = sq_sum[CNTW-1:0];
        end
    end

    always_comb begin
        cnt_dec  = global_stall ? cnt_reg - 1'b1 : '0;
        cnt_next = (stall_load && (stall_cycles > cnt_dec)) ? stall_cycles : cnt_dec;
    end

    assign squash_cnt = sq_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg  <= '0;
            cnt_reg    <= '0;
            sq_cnt_reg <= '0;
        end else begin
            valid_reg  <= valid_next;
            cnt_reg    <= cnt_next;
            sq_cnt_reg <= sq_cnt_next;
        end
    end

endmodule
